// File: rtl/bc_rx_transfer_if.sv
// -----------------------------------------------------------------------------
// bc_rx_transfer_if
//
// Link-side bundle of the BC "RT -> BC" transfer engine: the word path to the
// Manchester encoder, the word path from the Manchester decoder, and the write
// port of the local 32x16 receive buffer.
//
// Handshake semantics (all signals synchronous to the engine clock):
//   tx_ready  one-cycle strobe from the engine; tx_data/tx_cd are valid in
//             that cycle and tx_data/tx_cd hold afterwards. There is no
//             back-pressure on the strobe itself: the engine only issues a word
//             when the encoder is known idle, and it tracks completion by
//             watching tx_busy go high and then low again.
//   rx_valid  one-cycle strobe from the decoder; rx_data/rx_cd/p_error are
//             valid only in that cycle. At most one word per cycle, and
//             back-to-back strobes are legal.
//   mem_we    one-cycle write strobe from the engine; mem_addr/mem_data are
//             valid in that cycle. The buffer always accepts the write.
//
// Modports:
//   master  the transfer engine (drives tx_*, mem_*; samples tx_busy, rx_*)
//   slave   encoder/decoder/buffer side (the opposite directions)
// -----------------------------------------------------------------------------
interface bc_rx_transfer_if;
  // Encoder side
  logic [15:0] tx_data;
  logic        tx_cd;
  logic        tx_ready;
  logic        tx_busy;
  // Decoder side
  logic [15:0] rx_data;
  logic        rx_cd;
  logic        rx_valid;
  logic        p_error;
  // Receive buffer write port
  logic [4:0]  mem_addr;
  logic [15:0] mem_data;
  logic        mem_we;

  modport master (
    output tx_data,
    output tx_cd,
    output tx_ready,
    input  tx_busy,
    input  rx_data,
    input  rx_cd,
    input  rx_valid,
    input  p_error,
    output mem_addr,
    output mem_data,
    output mem_we
  );

  modport slave (
    input  tx_data,
    input  tx_cd,
    input  tx_ready,
    output tx_busy,
    output rx_data,
    output rx_cd,
    output rx_valid,
    output p_error,
    input  mem_addr,
    input  mem_data,
    input  mem_we
  );
endinterface

// File: rtl/bc_rx_transfer.sv
// -----------------------------------------------------------------------------
// bc_rx_transfer
//
// Bus-controller side MKIO (GOST 52070) "RT -> BC" transfer engine. A start
// pulse latches the target RT address, subaddress and word count, sends a
// transmit command word, waits for the encoder to finish, then waits for the
// RT status word and stores the following data words into a 32x16 buffer.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        one-cycle request, accepted only while idle (busy=0)
//   rt_addr      target RT address, latched on an accepted start
//   sub_addr     subaddress, latched on an accepted start
//   word_cnt     data word count (0 encodes 32), latched on an accepted start
//   link         encoder / decoder / buffer bundle (master side)
//   status_word  last status word received
//   busy         transaction in progress
//   done         one-cycle end-of-transaction pulse
//   err_timeout  no status word / data word inside the response window
//   err_parity   parity error on the status word or a data word
//   err_addr     status word carries a different RT address
//   err_format   command/status sync seen where a data word was expected
//   dbg_state    current FSM state (debug visibility)
//
// All outputs are registered: every output reflects the decision taken in the
// previous state, so mem_we follows the rx_valid cycle by one edge and done
// follows the last write / error detection by one edge.
// -----------------------------------------------------------------------------
module bc_rx_transfer #(
  parameter logic [15:0] RESP_TIMEOUT = 16'd200
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [4:0]              rt_addr,
  input  logic [4:0]              sub_addr,
  input  logic [4:0]              word_cnt,
  bc_rx_transfer_if.master        link,
  output logic [15:0]             status_word,
  output logic                    busy,
  output logic                    done,
  output logic                    err_timeout,
  output logic                    err_parity,
  output logic                    err_addr,
  output logic                    err_format,
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_SEND_CMD    = 3'd1,
    S_WAIT_TX     = 3'd2,
    S_WAIT_STATUS = 3'd3,
    S_RX_DATA     = 3'd4,
    S_DONE        = 3'd5
  } state_e;

  state_e      state_q, state_d;

  // Latched transaction parameters
  logic [4:0]  rt_q, rt_d;
  logic [4:0]  sub_q, sub_d;
  logic [4:0]  wc_q, wc_d;
  logic [5:0]  n_q, n_d;            // effective word count, 1..32

  // Working counters
  logic [4:0]  idx_q, idx_d;        // buffer address of the next data word
  logic [15:0] timer_q, timer_d;    // silent cycles left in the response window
  logic        tx_seen_q, tx_seen_d;

  // Registered outputs
  logic [15:0] tx_data_q, tx_data_d;
  logic        tx_cd_q, tx_cd_d;
  logic        tx_ready_q, tx_ready_d;
  logic [4:0]  mem_addr_q, mem_addr_d;
  logic [15:0] mem_data_q, mem_data_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] status_q, status_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_timeout_q, err_timeout_d;
  logic        err_parity_q, err_parity_d;
  logic        err_addr_q, err_addr_d;
  logic        err_format_q, err_format_d;

  logic        timer_expired;
  logic        last_word;

  // The timer is loaded with RESP_TIMEOUT and counts silent cycles down; it
  // expires on the cycle that would take it from 1 to 0, so the engine gives
  // up after exactly RESP_TIMEOUT silent cycles and done appears
  // RESP_TIMEOUT+1 edges after the window opened. A zero window expires on
  // the first silent cycle.
  assign timer_expired = (timer_q <= 16'd1);

  // n_q is never 0, so n_q - 1 does not wrap.
  assign last_word = ({1'b0, idx_q} == (n_q - 6'd1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and next register values
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    rt_d          = rt_q;
    sub_d         = sub_q;
    wc_d          = wc_q;
    n_d           = n_q;
    idx_d         = idx_q;
    timer_d       = timer_q;
    tx_seen_d     = tx_seen_q;
    tx_data_d     = tx_data_q;
    tx_cd_d       = tx_cd_q;
    tx_ready_d    = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_data_d    = mem_data_q;
    mem_we_d      = 1'b0;
    status_d      = status_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_timeout_d = err_timeout_q;
    err_parity_d  = err_parity_q;
    err_addr_d    = err_addr_q;
    err_format_d  = err_format_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rt_d          = rt_addr;
          sub_d         = sub_addr;
          wc_d          = word_cnt;
          n_d           = (word_cnt == 5'd0) ? 6'd32 : {1'b0, word_cnt};
          err_timeout_d = 1'b0;
          err_parity_d  = 1'b0;
          err_addr_d    = 1'b0;
          err_format_d  = 1'b0;
          busy_d        = 1'b1;
          state_d       = S_SEND_CMD;
        end
      end

      S_SEND_CMD: begin
        // Transmit command word: RT address, T/R=1 (RT transmits), subaddress,
        // raw word count field (0 stays 0 on the wire).
        tx_data_d  = {rt_q, 1'b1, sub_q, wc_q};
        tx_cd_d    = 1'b1;
        tx_ready_d = 1'b1;
        tx_seen_d  = 1'b0;
        state_d    = S_WAIT_TX;
      end

      S_WAIT_TX: begin
        // The response window opens only once the encoder has actually
        // started and then finished the command word.
        if (link.tx_busy) begin
          tx_seen_d = 1'b1;
        end else if (tx_seen_q) begin
          timer_d = RESP_TIMEOUT;
          idx_d   = 5'd0;
          state_d = S_WAIT_STATUS;
        end
      end

      S_WAIT_STATUS: begin
        // A data-sync word here is noise: it neither answers nor stops the
        // response window.
        if (link.rx_valid && link.rx_cd) begin
          status_d = link.rx_data;
          if (link.p_error) begin
            err_parity_d = 1'b1;
            state_d      = S_DONE;
          end else if (link.rx_data[15:11] != rt_q) begin
            err_addr_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            timer_d = RESP_TIMEOUT;
            state_d = S_RX_DATA;
          end
        end else if (timer_expired) begin
          err_timeout_d = 1'b1;
          state_d       = S_DONE;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end

      S_RX_DATA: begin
        if (link.rx_valid) begin
          if (link.rx_cd) begin
            err_format_d = 1'b1;
            state_d      = S_DONE;
          end else begin
            // A word with bad parity is still stored so the host can inspect
            // it; the transfer then stops.
            mem_addr_d = idx_q;
            mem_data_d = link.rx_data;
            mem_we_d   = 1'b1;
            timer_d    = RESP_TIMEOUT;
            if (link.p_error) begin
              err_parity_d = 1'b1;
              state_d      = S_DONE;
            end else if (last_word) begin
              state_d = S_DONE;
            end else begin
              idx_d = idx_q + 5'd1;
            end
          end
        end else if (timer_expired) begin
          err_timeout_d = 1'b1;
          state_d       = S_DONE;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rt_q          <= 5'd0;
      sub_q         <= 5'd0;
      wc_q          <= 5'd0;
      n_q           <= 6'd0;
      idx_q         <= 5'd0;
      timer_q       <= 16'd0;
      tx_seen_q     <= 1'b0;
      tx_data_q     <= 16'd0;
      tx_cd_q       <= 1'b0;
      tx_ready_q    <= 1'b0;
      mem_addr_q    <= 5'd0;
      mem_data_q    <= 16'd0;
      mem_we_q      <= 1'b0;
      status_q      <= 16'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_parity_q  <= 1'b0;
      err_addr_q    <= 1'b0;
      err_format_q  <= 1'b0;
    end else begin
      rt_q          <= rt_d;
      sub_q         <= sub_d;
      wc_q          <= wc_d;
      n_q           <= n_d;
      idx_q         <= idx_d;
      timer_q       <= timer_d;
      tx_seen_q     <= tx_seen_d;
      tx_data_q     <= tx_data_d;
      tx_cd_q       <= tx_cd_d;
      tx_ready_q    <= tx_ready_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
      mem_we_q      <= mem_we_d;
      status_q      <= status_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_timeout_q <= err_timeout_d;
      err_parity_q  <= err_parity_d;
      err_addr_q    <= err_addr_d;
      err_format_q  <= err_format_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign link.tx_data  = tx_data_q;
  assign link.tx_cd    = tx_cd_q;
  assign link.tx_ready = tx_ready_q;
  assign link.mem_addr = mem_addr_q;
  assign link.mem_data = mem_data_q;
  assign link.mem_we   = mem_we_q;

  assign status_word   = status_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_timeout   = err_timeout_q;
  assign err_parity    = err_parity_q;
  assign err_addr      = err_addr_q;
  assign err_format    = err_format_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_bc_rx_transfer.sv
// -----------------------------------------------------------------------------
// tb_bc_rx_transfer
//
// Bench for bc_rx_transfer with a short response window. Each transaction is
// described by its inputs and an injected condition; the expected buffer
// writes, flags, status word and done timing are derived from the transfer
// rules and compared with what a monitor collects from the DUT.
// -----------------------------------------------------------------------------
module tb_bc_rx_transfer;
  localparam logic [15:0] T = 16'd10;

  localparam int K_NONE      = 0;  // complete transfer
  localparam int K_ST_PAR    = 1;  // parity error on the status word
  localparam int K_DATA_PAR  = 2;  // parity error on data word p
  localparam int K_FORMAT    = 3;  // command sync after p data words
  localparam int K_NO_STATUS = 4;  // RT never answers
  localparam int K_DATA_TO   = 5;  // silence after p data words

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [4:0]  rt_addr = '0, sub_addr = '0, word_cnt = '0;
  logic [15:0] status_word;
  logic        busy, done, err_timeout, err_parity, err_addr, err_format;
  logic [2:0]  dbg_state;

  bc_rx_transfer_if link();

  bc_rx_transfer #(.RESP_TIMEOUT(T)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .rt_addr     (rt_addr),
    .sub_addr    (sub_addr),
    .word_cnt    (word_cnt),
    .link        (link),
    .status_word (status_word),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout),
    .err_parity  (err_parity),
    .err_addr    (err_addr),
    .err_format  (err_format),
    .dbg_state   (dbg_state)
  );

  // ---------------------------------------------------------------- bookkeeping
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [20:0] exp_q[$];
  logic [20:0] got_q[$];
  int          tx_cnt = 0, tx_cyc = 0, done_cnt = 0, done_cyc = 0, last_we_cyc = 0;
  logic [16:0] tx_word = '0;
  logic        busy_at_done = 1'b0;

  int          s_cyc, entry_cyc, last_rx_cyc;
  logic [15:0] exp_status = '0;
  logic [15:0] words[32];

  logic [4:0]  r_rt, r_sub, r_wc;
  logic [15:0] r_st;
  int          r_n, r_kind, r_p;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples DUT outputs just after each active edge.
  always @(posedge clk) begin
    #1;
    if (link.mem_we) begin
      got_q.push_back({link.mem_addr, link.mem_data});
      last_we_cyc = cyc;
    end
    if (link.tx_ready) begin
      tx_cnt++;
      tx_cyc  = cyc;
      tx_word = {link.tx_cd, link.tx_data};
    end
    if (done) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------- checker
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // All drivers are entered and left on a falling edge.
  task automatic issue_start(input logic [4:0] rt, input logic [4:0] sub, input logic [4:0] wc);
    start    = 1'b1;
    rt_addr  = rt;
    sub_addr = sub;
    word_cnt = wc;
    s_cyc    = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic tx_handshake();
    repeat ($urandom_range(0, 2)) @(negedge clk);
    link.tx_busy = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    link.tx_busy = 1'b0;
    entry_cyc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic rx_word(input logic [15:0] d, input logic cd, input logic pe);
    link.rx_valid = 1'b1;
    link.rx_data  = d;
    link.rx_cd    = cd;
    link.p_error  = pe;
    last_rx_cyc   = cyc;
    @(negedge clk);
    link.rx_valid = 1'b0;
    link.rx_cd    = 1'b0;
    link.p_error  = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    for (int i = 0; i < 400 && done_cnt == prev; i++) @(negedge clk);
    check("done_seen", 64'(done_cnt), 64'(prev + 1));
  endtask

  // ---------------------------------------------------------------- transaction
  task automatic run_txn(input logic [4:0] rt, input logic [4:0] sub, input logic [4:0] wc,
                         input int kind, input int p, input logic [15:0] st,
                         input logic stray, input logic poke);
    int   n, m, prev_done, prev_tx, exp_done_cyc;
    logic e_t, e_p, e_a, e_f, write_end;
    logic [20:0] g, e;
    n = (wc == 5'd0) ? 32 : int'(wc);
    e_t = 1'b0; e_p = 1'b0; e_a = 1'b0; e_f = 1'b0; write_end = 1'b0;
    exp_done_cyc = 0;
    exp_q.delete();
    got_q.delete();
    prev_done = done_cnt;
    prev_tx   = tx_cnt;

    issue_start(rt, sub, wc);
    check("busy_after_start", 64'(busy), 64'd1);
    @(negedge clk);
    check("tx_ready_cycle", 64'(tx_cyc), 64'(s_cyc + 2));
    check("tx_cmd_word", 64'(tx_word), 64'({1'b1, rt, 1'b1, sub, wc}));
    tx_handshake();

    if (poke) begin
      start   = 1'b1;
      rt_addr = ~rt;
      @(negedge clk);
      start = 1'b0;
    end
    if (stray) rx_word(16'($urandom), 1'b0, 1'b0);

    if (kind == K_NO_STATUS) begin
      e_t          = 1'b1;
      exp_done_cyc = entry_cyc + int'(T) + 1;
    end else begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      rx_word(st, 1'b1, kind == K_ST_PAR);
      exp_status = st;
      if (kind == K_ST_PAR) begin
        e_p          = 1'b1;
        exp_done_cyc = last_rx_cyc + 2;
      end else if (st[15:11] != rt) begin
        e_a          = 1'b1;
        exp_done_cyc = last_rx_cyc + 2;
      end else begin
        m = (kind == K_NONE) ? n : ((kind == K_DATA_PAR) ? p + 1 : p);
        for (int i = 0; i < m; i++) begin
          if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
          rx_word(words[i], 1'b0, (kind == K_DATA_PAR) && (i == p));
          exp_q.push_back({5'(i), words[i]});
        end
        if (kind == K_NONE || kind == K_DATA_PAR) begin
          e_p          = (kind == K_DATA_PAR);
          write_end    = 1'b1;
          exp_done_cyc = last_rx_cyc + 2;
        end else if (kind == K_FORMAT) begin
          rx_word(16'($urandom), 1'b1, 1'b0);
          e_f          = 1'b1;
          exp_done_cyc = last_rx_cyc + 2;
        end else begin
          e_t          = 1'b1;
          exp_done_cyc = last_rx_cyc + int'(T) + 2;
        end
      end
    end

    wait_done(prev_done);
    check("done_cycle", 64'(done_cyc), 64'(exp_done_cyc));
    check("busy_at_done", 64'(busy_at_done), 64'd0);
    check("single_cmd", 64'(tx_cnt), 64'(prev_tx + 1));
    check("err_timeout", 64'(err_timeout), 64'(e_t));
    check("err_parity", 64'(err_parity), 64'(e_p));
    check("err_addr", 64'(err_addr), 64'(e_a));
    check("err_format", 64'(err_format), 64'(e_f));
    check("status_word", 64'(status_word), 64'(exp_status));
    check("write_count", 64'(got_q.size()), 64'(exp_q.size()));
    if (write_end) check("we_to_done", 64'(last_we_cyc + 1), 64'(done_cyc));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check("mem_write", 64'(g), 64'(e));
    end
    @(negedge clk);
    check("done_width", 64'(done), 64'd0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    link.tx_busy  = 1'b0;
    link.rx_data  = '0;
    link.rx_cd    = 1'b0;
    link.rx_valid = 1'b0;
    link.p_error  = 1'b0;

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    check("reset_outputs", 64'({link.tx_data, link.tx_cd, link.tx_ready, link.mem_addr,
                                 link.mem_data, link.mem_we, status_word, busy, done,
                                 err_timeout, err_parity, err_addr, err_format}), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Normal 3-word transfer with the documented command word
    words[0] = 16'hAAAA; words[1] = 16'hBBBB; words[2] = 16'hCCCC;
    run_txn(5'd1, 5'd2, 5'd3, K_NONE, 0, 16'h0800, 1'b0, 1'b0);
    check("cmd_0C43", 64'(tx_word), 64'h10C43);

    // word_cnt = 0 means 32 words
    for (int i = 0; i < 32; i++) words[i] = 16'($urandom);
    run_txn(5'd7, 5'd9, 5'd0, K_NONE, 0, {5'd7, 11'($urandom)}, 1'b0, 1'b0);

    // No status word, with a stray data-sync word inside the window
    run_txn(5'd3, 5'd4, 5'd2, K_NO_STATUS, 0, 16'h0, 1'b1, 1'b0);

    // Wrong address in the status word
    run_txn(5'd1, 5'd2, 5'd3, K_NONE, 0, 16'h1000, 1'b0, 1'b0);

    // Parity error on the second of four data words
    for (int i = 0; i < 32; i++) words[i] = 16'($urandom);
    run_txn(5'd12, 5'd5, 5'd4, K_DATA_PAR, 1, {5'd12, 11'h0}, 1'b0, 1'b0);

    // Parity error on the status word, format error, data-phase timeout
    run_txn(5'd20, 5'd1, 5'd6, K_ST_PAR, 0, {5'd20, 11'h155}, 1'b0, 1'b0);
    run_txn(5'd20, 5'd1, 5'd6, K_FORMAT, 2, {5'd20, 11'h001}, 1'b0, 1'b0);
    run_txn(5'd9, 5'd30, 5'd8, K_DATA_TO, 3, {5'd9, 11'h000}, 1'b0, 1'b0);

    // start while busy must not disturb the latched RT address
    run_txn(5'd17, 5'd3, 5'd2, K_NONE, 0, {5'd17, 11'h010}, 1'b0, 1'b1);

    // Randomized transactions
    for (int t = 0; t < 12; t++) begin
      r_rt   = 5'($urandom);
      r_sub  = 5'($urandom);
      r_wc   = 5'($urandom);
      r_n    = (r_wc == 5'd0) ? 32 : int'(r_wc);
      r_kind = $urandom_range(0, 5);
      r_p    = $urandom_range(0, r_n - 1);
      for (int i = 0; i < 32; i++) words[i] = 16'($urandom);
      r_st   = {(($urandom_range(0, 3) == 0) ? 5'($urandom) : r_rt), 11'($urandom)};
      run_txn(r_rt, r_sub, r_wc, r_kind, r_p, r_st,
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    // Reset asserted in the data phase: immediate clear, no done pulse
    got_q.delete();
    r_n = done_cnt;
    issue_start(5'd1, 5'd3, 5'd5);
    @(negedge clk);
    tx_handshake();
    rx_word({5'd1, 11'h0}, 1'b1, 1'b0);
    rx_word(16'h1234, 1'b0, 1'b0);
    check("pre_reset_busy", 64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("reset_mid_outputs", 64'({link.tx_data, link.tx_cd, link.tx_ready, link.mem_addr,
                                     link.mem_data, link.mem_we, status_word, busy, done,
                                     err_timeout, err_parity, err_addr, err_format}), 64'd0);
    exp_status = 16'h0;
    repeat (3) @(negedge clk);
    check("no_done_on_reset", 64'(done_cnt), 64'(r_n));
    reset_n = 1'b1;
    @(negedge clk);

    // Recovery after reset
    for (int i = 0; i < 32; i++) words[i] = 16'($urandom);
    run_txn(5'd30, 5'd31, 5'd1, K_NONE, 0, {5'd30, 11'h7FF}, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bc_rx_transfer.md
# bc_rx_transfer

Bus-controller-side MKIO (GOST 52070) "RT → BC" transfer engine. On a start pulse it builds and sends a transmit command word to a remote terminal and waits for the status word. It then receives the requested number of data words and writes them into a local 32×16 buffer. It sits between the BC host logic and the Manchester encoder/decoder, on the opposite end of the link from the RT data-transmit devices.

## Interface
- RESP_TIMEOUT, 16'd200: maximum idle clock cycles while waiting for the status word, and between consecutive data words.

- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- rt_addr  in  5  target RT address; latched on an accepted start.
- sub_addr  in  5  subaddress; latched on an accepted start.
- word_cnt  in  5  data word count; 0 means 32. Latched on an accepted start.
- tx_data  out  16  word to the encoder.
- tx_cd  out  1  1 = command sync, 0 = data sync.
- tx_ready  out  1  one-cycle strobe: tx_data/tx_cd valid.
- tx_busy  in  1  encoder is transmitting.
- rx_data  in  16  decoded word.
- rx_cd  in  1  1 = command/status sync received.
- rx_valid  in  1  one-cycle strobe: rx_data/rx_cd/p_error valid.
- p_error  in  1  parity error on the current rx word.
- mem_addr  out  5  buffer write address.
- mem_data  out  16  buffer write data.
- mem_we  out  1  one-cycle write enable.
- status_word  out  16  last received status word.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle end-of-transaction pulse.
- err_timeout, err_parity, err_addr, err_format  out  1 each  sticky error flags, cleared on the next accepted start.

## Operation
- **Reset value.** Every output resets to 0 and the FSM goes to IDLE.
- **Start.** An accepted start latches rt_addr, sub_addr and word_cnt, computes N = (word_cnt==0) ? 32 : word_cnt (6-bit), clears all err_* flags, sets busy=1, and goes to SEND_CMD.
- **start while busy.** Ignored.
- **IDLE.** Waits for start.
- **SEND_CMD.** Drives tx_data = {rt_addr, 1'b1, sub_addr, word_cnt}, tx_cd=1 and tx_ready=1 for one cycle, then goes to WAIT_TX. tx_data holds its value afterwards.
- **WAIT_TX.** Waits until tx_busy has been seen high and then low. It then loads the timer with RESP_TIMEOUT, clears the word counter, and goes to WAIT_STATUS.
- **WAIT_STATUS.** Timer decrements every cycle without rx_valid.
  - rx_valid with rx_cd=1: latch status_word = rx_data.
    - If p_error: set err_parity and go to DONE.
    - Else if rx_data[15:11] != rt_addr: set err_addr and go to DONE.
    - Otherwise reload the timer and go to RX_DATA.
  - rx_valid with rx_cd=0: ignored, and the timer keeps running.
  - Timer at 0 with no rx_valid: set err_timeout and go to DONE.
- **RX_DATA.** Handles each received word as follows:
  - rx_valid with rx_cd=0: mem_addr = word counter, mem_data = rx_data, mem_we=1 for one cycle. The timer reloads.
    - If p_error: the word is still written, err_parity is set, and the FSM goes to DONE.
    - If the counter equals N-1: go to DONE.
    - Otherwise increment the counter.
  - rx_valid with rx_cd=1: set err_format, no write, go to DONE.
  - Timer expiry: set err_timeout and go to DONE. Words already written remain in the buffer.
- **DONE.** done=1 and busy=0 for one cycle, then IDLE. status_word and the err_* flags hold until the next accepted start.
- **Status bits.** Message-error and other status bits are only reported through status_word; they trigger no action.

## Timing
- start accepted at edge k → busy=1 after k. SEND_CMD occupies cycle k+1, so tx_ready is high after edge k+1 for exactly one cycle.
- Timeout fires RESP_TIMEOUT+1 cycles after entering WAIT_STATUS, or after the last valid word in RX_DATA, if no rx_valid arrives.
- mem_we rises on the edge following the rx_valid cycle and lasts one cycle.
- done follows, one edge later, the final mem_we cycle or the error-detection edge.
- Maximum one rx word per cycle. Back-to-back rx_valid strobes are all written.
- reset_n low mid-transaction: immediate abort, all outputs 0, no done pulse.

## Test plan
- **Normal 3-word transfer.** rt_addr=5'd1, sub=5'd2, word_cnt=3 → tx_data=16'h0C43, tx_cd=1. Status 16'h0800 plus words AAAA, BBBB, CCCC → mem addresses 0..2 written, done pulse, all err_*=0.
- **word_cnt=0.** 32 data words after status → 32 writes at addresses 0..31, done after the write at address 31.
- **Timeout.** RESP_TIMEOUT=10 and no status → err_timeout=1 and done exactly 11 cycles after WAIT_STATUS entry, no mem_we.
- **Wrong address.** Status 16'h1000 (address 2) for rt_addr=1 → err_addr=1, status_word=16'h1000, no writes.
- **Parity error.** p_error on the second data word of 4 → that word is written to address 1, err_parity=1, done, no third write.
- **Reset and busy start.** reset_n asserted in RX_DATA → outputs 0 at once. A start pulse while busy → no new tx_ready and the latched rt_addr is unchanged.
